// File: rtl/display_share_arbiter.sv
// Round-robin owner of the 8-digit display: two level-sensitive requesters, a minimum hold
// time per grant, and registered digit outputs loaded from the current owner's word.
module display_share_arbiter #(
  parameter int unsigned ANCHO       = 4,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_a,
  input  logic [8*ANCHO-1:0] data_a,
  input  logic               req_b,
  input  logic [8*ANCHO-1:0] data_b,
  output logic               gnt_a,
  output logic               gnt_b,
  output logic               busy,
  output logic [ANCHO-1:0]   Dis0,
  output logic [ANCHO-1:0]   Dis1,
  output logic [ANCHO-1:0]   Dis2,
  output logic [ANCHO-1:0]   Dis3,
  output logic [ANCHO-1:0]   Dis4,
  output logic [ANCHO-1:0]   Dis5,
  output logic [ANCHO-1:0]   Dis6,
  output logic [ANCHO-1:0]   Dis7
);

  typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ptr_b, w_ptr_b_nxt;  // 1: B wins the next IDLE collision
  logic [ANCHO-1:0] r_dis [8];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_b_nxt = r_ptr_b;
    unique case (r_state)
      StIdle: begin
        if (req_a && (!req_b || !r_ptr_b)) w_state_nxt = StOwnA;
        else if (req_b)                    w_state_nxt = StOwnB;
      end
      StOwnA: begin
        if (r_cnt != '0)  w_cnt_nxt   = r_cnt - CNT_W'(1);
        else if (req_b)   w_state_nxt = StOwnB;
        else if (!req_a)  w_state_nxt = StIdle;
      end
      StOwnB: begin
        if (r_cnt != '0)  w_cnt_nxt   = r_cnt - CNT_W'(1);
        else if (req_a)   w_state_nxt = StOwnA;
        else if (!req_b)  w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    // Every new grant restarts the hold window and favours the other side next time.
    if (w_state_nxt != r_state) begin
      if (w_state_nxt == StOwnA) begin
        w_cnt_nxt   = HoldLoad;
        w_ptr_b_nxt = 1'b1;
      end else if (w_state_nxt == StOwnB) begin
        w_cnt_nxt   = HoldLoad;
        w_ptr_b_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ptr_b <= 1'b0;
      for (int i = 0; i < 8; i++) r_dis[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr_b <= w_ptr_b_nxt;
      if (r_state == StOwnA) begin
        for (int i = 0; i < 8; i++) r_dis[i] <= data_a[i*ANCHO +: ANCHO];
      end else if (r_state == StOwnB) begin
        for (int i = 0; i < 8; i++) r_dis[i] <= data_b[i*ANCHO +: ANCHO];
      end
    end
  end

  assign gnt_a = (r_state == StOwnA);
  assign gnt_b = (r_state == StOwnB);
  assign busy  = gnt_a | gnt_b;

  assign Dis0 = r_dis[0];
  assign Dis1 = r_dis[1];
  assign Dis2 = r_dis[2];
  assign Dis3 = r_dis[3];
  assign Dis4 = r_dis[4];
  assign Dis5 = r_dis[5];
  assign Dis6 = r_dis[6];
  assign Dis7 = r_dis[7];

endmodule

// File: tb/tb_display_share_arbiter.sv
// Scoreboard bench: directed steps push hand-computed expectations; a negedge monitor pops them
// and compares grants, busy and the digit outputs of a HOLD=4 and a HOLD=1 instance.
module tb_display_share_arbiter;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic        req_a, req_b;
  logic [31:0] data_a, data_b;

  logic       ga0, gb0, bz0, ga1, gb1, bz1;
  logic [3:0] d0 [8];
  logic [3:0] d1 [8];

  typedef struct {
    string       nm;
    logic        ga;
    logic        gb;
    logic [31:0] dis;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  display_share_arbiter #(.ANCHO(4), .HOLD_CYCLES(4), .CNT_W(26)) u_dut0 (
    .clk(clk), .rst(rst), .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .gnt_a(ga0), .gnt_b(gb0), .busy(bz0),
    .Dis0(d0[0]), .Dis1(d0[1]), .Dis2(d0[2]), .Dis3(d0[3]),
    .Dis4(d0[4]), .Dis5(d0[5]), .Dis6(d0[6]), .Dis7(d0[7])
  );

  display_share_arbiter #(.ANCHO(4), .HOLD_CYCLES(1), .CNT_W(26)) u_dut1 (
    .clk(clk), .rst(rst1), .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .gnt_a(ga1), .gnt_b(gb1), .busy(bz1),
    .Dis0(d1[0]), .Dis1(d1[1]), .Dis2(d1[2]), .Dis3(d1[3]),
    .Dis4(d1[4]), .Dis5(d1[5]), .Dis6(d1[6]), .Dis7(d1[7])
  );

  function automatic logic [31:0] pack(input logic [3:0] d [8]);
    return {d[7], d[6], d[5], d[4], d[3], d[2], d[1], d[0]};
  endfunction

  task automatic check(input string nm, input logic ga, gb, bz, input logic [31:0] dis,
                       input exp_t e);
    n_cmp++;
    if ({ga, gb, bz} !== {e.ga, e.gb, e.ga | e.gb}) begin
      n_bad++;
      $display("FAIL %s grants: got ga=%b gb=%b busy=%b, want ga=%b gb=%b busy=%b",
               nm, ga, gb, bz, e.ga, e.gb, e.ga | e.gb);
    end
    n_cmp++;
    if (dis !== e.dis) begin
      n_bad++;
      $display("FAIL %s dis: got %h, want %h", nm, dis, e.dis);
    end
  endtask

  // Monitor: outputs are stable between posedges, so the negedge sees the post-edge values.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check({"h4 ", e.nm}, ga0, gb0, bz0, pack(d0), e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check({"h1 ", e.nm}, ga1, gb1, bz1, pack(d1), e);
    end
  end

  task automatic drive(input logic r, ra, rb, input logic [31:0] da, db);
    rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db;
  endtask

  // One clock edge; expectation describes outputs after that edge.
  task automatic step(input string nm, input bit sel, input logic ga, gb, input logic [31:0] dis);
    exp_t e;
    @(posedge clk);
    #1;
    e.nm = nm; e.ga = ga; e.gb = gb; e.dis = dis;
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  localparam logic [31:0] DA = 32'h1234_5678;
  localparam logic [31:0] DB = 32'hCAFE_F00D;
  localparam logic [31:0] DC = 32'h9ABC_DEF0;

  initial begin
    rst1 = 1'b1;
    // Reset with both requesting
    drive(1, 1, 1, DA, DB);
    step("rst0", 0, 0, 0, 32'h0);
    step("rst1", 0, 0, 0, 32'h0);
    // Release: A favoured, both keep requesting and alternate every 4 cycles
    rst = 0;
    step("e0_gntA", 0, 1, 0, 32'h0);
    step("e1_loadA", 0, 1, 0, DA);
    step("e2", 0, 1, 0, DA);
    step("e3", 0, 1, 0, DA);
    step("e4_toB", 0, 0, 1, DA);
    step("e5_loadB", 0, 0, 1, DB);
    step("e6", 0, 0, 1, DB);
    step("e7", 0, 0, 1, DB);
    step("e8_toA", 0, 1, 0, DB);
    step("e9_loadA", 0, 1, 0, DA);
    step("e10", 0, 1, 0, DA);
    step("e11", 0, 1, 0, DA);
    // Both drop at expiry -> IDLE
    drive(0, 0, 0, DA, DB);
    step("e12_idle", 0, 0, 0, DA);
    // Single-cycle pulse on B: held 4 cycles regardless
    drive(0, 0, 1, DA, DB);
    step("e13_gntB", 0, 0, 1, DA);
    req_b = 0;
    step("e14_holdB", 0, 0, 1, DB);
    step("e15_holdB", 0, 0, 1, DB);
    step("e16_holdB", 0, 0, 1, DB);
    step("e17_idle", 0, 0, 0, DB);
    data_b = 32'h1111_1111;
    step("e18_keep", 0, 0, 0, DB);
    // A owns past expiry, then B arrives -> direct handover
    drive(0, 1, 0, DA, DC);
    step("e19_gntA", 0, 1, 0, DB);
    step("e20", 0, 1, 0, DA);
    step("e21", 0, 1, 0, DA);
    step("e22", 0, 1, 0, DA);
    step("e23_stayA", 0, 1, 0, DA);
    step("e24_stayA", 0, 1, 0, DA);
    req_b = 1;
    step("e25_handover", 0, 0, 1, DA);
    step("e26_loadB", 0, 0, 1, DC);
    // Reset mid-grant with counter at 2, then A wins first
    rst = 1;
    step("e27_rst", 0, 0, 0, 32'h0);
    rst = 0;
    step("e28_ptrA", 0, 1, 0, 32'h0);
    step("e29_loadA", 0, 1, 0, DA);
    // HOLD_CYCLES=1 instance: alternate every cycle
    drive(1, 1, 1, DA, DB);
    rst1 = 1;
    step("h1_rst", 1, 0, 0, 32'h0);
    rst = 0; rst1 = 0;
    step("h1_e0", 1, 1, 0, 32'h0);
    step("h1_e1", 1, 0, 1, DA);
    step("h1_e2", 1, 1, 0, DB);
    step("h1_e3", 1, 0, 1, DA);
    step("h1_e4", 1, 1, 0, DB);
    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
    @(posedge clk);
    if ((q0.size() + q1.size()) > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
